// File: rtl/instr_encoder.sv
// instr_encoder: packs H2BP instruction fields into 32-bit words and
// streams them into instruction memory through a one-entry output register.
module instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int MEM_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        kind,
    input  logic [4:0]        opcode,
    input  logic [2:0]        operation,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic              full,
    output logic              done
);

    localparam logic [2:0] K_ALU3     = 3'd0;
    localparam logic [2:0] K_ALU2_OFF = 3'd1;
    localparam logic [2:0] K_ALU2_IMM = 3'd2;
    localparam logic [2:0] K_MEM      = 3'd3;
    localparam logic [2:0] K_JUMP     = 3'd4;
    localparam logic [2:0] K_BRANCH   = 3'd5;

    // Upper-opcode map: LW..SB is a contiguous block, J sits just above it.
    localparam logic [4:0] OP_LW = 5'd16;
    localparam logic [4:0] OP_SB = 5'd21;
    localparam logic [4:0] OP_J  = 5'd22;

    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W+1:0] DEPTH_W  = (ADDR_W+2)'(MEM_DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q;
    logic              done_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              err_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    logic              fit12;
    logic              fit16;
    logic              fit27;
    logic              is_mem;
    logic              legal;
    logic [31:0]       word;
    logic              accept;
    logic              wr_fire;
    logic [ADDR_W+1:0] committed;
    logic              room;

    // An immediate fits N signed bits when all bits above N-1 copy the sign.
    assign fit12  = (imm[31:11] == '0) | (imm[31:11] == '1);
    assign fit16  = (imm[31:15] == '0) | (imm[31:15] == '1);
    assign fit27  = (imm[31:26] == '0) | (imm[31:26] == '1);
    assign is_mem = (opcode >= OP_LW) & (opcode <= OP_SB);

    // Field packing and legality check for the bundle on the input port.
    always_comb begin
        word  = '0;
        legal = 1'b0;
        unique case (kind)
            K_ALU3: begin
                word  = {1'b0, operation, 1'b0, rd, rs1, rs2, imm[11:0]};
                legal = fit12;
            end
            K_ALU2_OFF: begin
                word  = {1'b0, operation, 1'b1, rd, rs1, imm[15:0], 1'b0};
                legal = fit16;
            end
            K_ALU2_IMM: begin
                word  = {1'b0, operation, 1'b1, rd, rs1, imm[15:0], 1'b1};
                legal = fit16;
            end
            K_MEM: begin
                word  = {opcode, rd, rs1, imm[15:0], 1'b0};
                legal = is_mem & fit16;
            end
            K_JUMP: begin
                word  = {OP_J, imm[26:0]};
                legal = fit27;
            end
            K_BRANCH: begin
                word  = {opcode, rd, rs1, imm[15:0], 1'b0};
                legal = opcode[4] & ~is_mem & (opcode != OP_J)
                      & (opcode[2:0] != 3'b111) & fit16;
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

    // A word still parked in the output register already owns a slot, so
    // accepting another one needs room for both before full is reached.
    assign committed = {1'b0, count_q} + {{(ADDR_W+1){1'b0}}, mem_we_q};
    assign room      = committed < DEPTH_W;
    assign in_ready  = (state_q == S_RUN) & room & (~mem_we_q | mem_ready);
    assign accept    = in_valid & in_ready;
    assign wr_fire   = mem_we_q & mem_ready;

    // Session control: IDLE -> RUN -> DRAIN -> IDLE with a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) state_q <= S_RUN;
                end
                S_RUN: begin
                    if (finish) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!mem_we_q) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Write pointer, word counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else if ((state_q == S_IDLE) && start) begin
            ptr_q   <= base_addr;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (wr_fire) begin
                ptr_q   <= ptr_q + PTR_ONE;
                count_q <= count_q + CNT_ONE;
            end
            if (accept && !legal) err_q <= 1'b1;
        end
    end

    // One-entry output register; it holds steady while memory stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (accept && legal) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= ptr_q + (wr_fire ? PTR_ONE : PTR_ZERO);
            mem_wdata_q <= word;
        end else if (wr_fire) begin
            mem_we_q    <= 1'b0;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign err       = err_q;
    assign full      = (count_q == DEPTH_C);
    assign done      = done_q;

endmodule
